// File: rtl/bk_adder_pipe_pkg.sv
// Shared constants and helpers for the pipelined Brent-Kung adder.
// The stage payload struct is declared inside the top module because its width follows WIDTH.
package bk_adder_pkg;

    // A PIPE value at or above each threshold inserts that register stage.
    localparam int unsigned PIPE_UP_REG = 2;  // register after the up-sweep
    localparam int unsigned PIPE_GP_REG = 3;  // register after G/P generation

    function automatic int unsigned bk_levels(input int unsigned width);
        int unsigned l;
        l = 0;
        while ((32'd1 << l) < width) l++;
        return l;
    endfunction

endpackage

// File: rtl/bk_adder_pipe_prefix_tree.sv
// Combinational Brent-Kung prefix network, split into up-sweep and down-sweep halves.
// Nodes that would reach past WIDTH are pruned, so any WIDTH >= 2 is supported.
module bk_prefix_tree
    import bk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 17
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] up_g,
    output logic [WIDTH-1:0] up_p,
    input  logic [WIDTH-1:0] dn_g,
    input  logic [WIDTH-1:0] dn_p,
    output logic [WIDTH-1:0] pre_g,
    output logic [WIDTH-1:0] pre_p
);

    localparam int unsigned LEVELS = bk_levels(WIDTH);

    // Each level writes and reads disjoint bit positions, so in-place updates are safe.
    always_comb begin
        up_g = g;
        up_p = p;
        for (int unsigned l = 1; l <= LEVELS; l++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (32'd1 << l)) == 0) begin
                    up_g[i] = up_g[i] | (up_p[i] & up_g[i - (32'd1 << (l - 1))]);
                    up_p[i] = up_p[i] & up_p[i - (32'd1 << (l - 1))];
                end
            end
        end
    end

    always_comb begin
        pre_g = dn_g;
        pre_p = dn_p;
        for (int unsigned l = LEVELS - 1; l >= 1; l--) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if ((((i + 1) % (32'd1 << l)) == (32'd1 << (l - 1))) && (i >= (32'd1 << l))) begin
                    pre_g[i] = pre_g[i] | (pre_p[i] & pre_g[i - (32'd1 << (l - 1))]);
                    pre_p[i] = pre_p[i] & pre_p[i - (32'd1 << (l - 1))];
                end
            end
        end
    end

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready handshakes and a signed-overflow flag.
// PIPE selects 1..3 register stages; the whole pipeline advances or holds as one unit.
module bk_adder_pipe
    import bk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned PIPE  = 2
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH:0]   S,
    output logic             OVF
);

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] p0;
        logic             c0;
        logic             xmsb;
        logic             ymsb;
        logic             valid;
    } stage_t;

    stage_t           gp_d, gp_q, up_d, up_q;
    logic [WIDTH-1:0] y_eff;
    logic [WIDTH-1:0] up_g, up_p, pre_g, pre_p;
    logic [WIDTH:0]   carry, sum_d;
    logic             ovf_d;
    logic             advance;

    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = advance;
    assign y_eff    = SUB ? ~Y : Y;

    always_comb begin
        gp_d.g     = X & y_eff;
        gp_d.p     = X ^ y_eff;
        gp_d.p0    = X ^ y_eff;
        gp_d.c0    = SUB ^ Cin;
        gp_d.xmsb  = X[WIDTH-1];
        gp_d.ymsb  = y_eff[WIDTH-1];
        gp_d.valid = IN_VALID;
    end

    generate
        if (PIPE >= PIPE_GP_REG) begin : g_gp_reg
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn)        gp_q <= '0;
                else if (advance) gp_q <= gp_d;
            end
        end else begin : g_gp_thru
            assign gp_q = gp_d;
        end
    endgenerate

    bk_prefix_tree #(.WIDTH(WIDTH)) u_tree (
        .g     (gp_q.g),
        .p     (gp_q.p),
        .up_g  (up_g),
        .up_p  (up_p),
        .dn_g  (up_q.g),
        .dn_p  (up_q.p),
        .pre_g (pre_g),
        .pre_p (pre_p)
    );

    // Only the group G/P change across the up-sweep; the rest of the payload rides along.
    always_comb begin
        up_d   = gp_q;
        up_d.g = up_g;
        up_d.p = up_p;
    end

    generate
        if (PIPE >= PIPE_UP_REG) begin : g_up_reg
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn)        up_q <= '0;
                else if (advance) up_q <= up_d;
            end
        end else begin : g_up_thru
            assign up_q = up_d;
        end
    endgenerate

    always_comb begin
        carry = {pre_g | (pre_p & {WIDTH{up_q.c0}}), up_q.c0};
        sum_d = {carry[WIDTH], up_q.p0 ^ carry[WIDTH-1:0]};
        ovf_d = (up_q.xmsb == up_q.ymsb) && (sum_d[WIDTH-1] != up_q.xmsb);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            OUT_VALID <= 1'b0;
            S         <= '0;
            OVF       <= 1'b0;
        end else if (advance) begin
            OUT_VALID <= up_q.valid;
            S         <= sum_d;
            OVF       <= ovf_d;
        end
    end

endmodule
